dct_mac_lanes: RTL and testbench

//  Multi-lane pipelined multiply-accumulate for the fdct datapath; generalises the single-lane macu (registered

---
 rtl/dct_mac_pkg.sv | 42 ++++
 rtl/dct_mac_lanes_if.sv | 25 ++
 rtl/dct_mac_lane.sv | 66 ++++++
 rtl/dct_mac_lanes.sv | 81 ++++++++
 tb/tb_dct_mac_lanes.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_mac_pkg.sv
// Shared defaults, saturating/wrapping adder and lane slice helper for the fdct MAC lanes.
`ifndef DCT_MAC_PKG_SV
`define DCT_MAC_PKG_SV

// Lane idx of a packed multi-lane vector whose lanes are w bits wide.
`define DCT_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package dct_mac_pkg;

  localparam int unsigned DefLanes    = 4;
  localparam int unsigned DefDwidth   = 8;
  localparam int unsigned DefCwidth   = 12;
  localparam int unsigned DefTerms    = 8;
  localparam int unsigned DefAccWidth = 23;
  localparam int unsigned DefSat      = 0;

  // Adds two sign-extended operands and checks the exact sum against a width-bit signed range.
  // Returns {ovf, sum}; the caller keeps sum[width-1:0]. Valid for width <= 63.
  function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int unsigned        width,
                                          input logic               sat);
    logic signed [64:0] s;
    logic signed [64:0] max_v;
    logic signed [64:0] min_v;
    logic               o;
    logic        [63:0] sum;
    s     = {a[63], a} + {b[63], b};
    max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
    min_v = -max_v - 65'sd1;
    o     = (s > max_v) || (s < min_v);
    if (o && sat) begin
      sum = s[64] ? min_v[63:0] : max_v[63:0];
    end else begin
      sum = s[63:0];
    end
    return {o, sum};
  endfunction

endpackage

`endif

// File: rtl/dct_mac_lanes_if.sv
// Term/result bus between the coefficient/sample feed, the MAC lanes and the zigzag stage.
interface dct_mac_lanes_if #(
  parameter int unsigned LANES     = dct_mac_pkg::DefLanes,
  parameter int unsigned DWIDTH    = dct_mac_pkg::DefDwidth,
  parameter int unsigned CWIDTH    = dct_mac_pkg::DefCwidth,
  parameter int unsigned ACC_WIDTH = dct_mac_pkg::DefAccWidth
);
  logic                       in_valid;
  logic                       dclr;
  logic [LANES*DWIDTH-1:0]    din;
  logic [LANES*CWIDTH-1:0]    coef;
  logic [LANES*ACC_WIDTH-1:0] result;
  logic                       out_valid;
  logic [LANES-1:0]           ovf;

  modport master (
    output in_valid, dclr, din, coef,
    input  result, out_valid, ovf
  );

  modport slave (
    input  in_valid, dclr, din, coef,
    output result, out_valid, ovf
  );
endinterface

// File: rtl/dct_mac_lane.sv
// One MAC lane: registered product, accumulator with sticky overflow, and completed-sum registers.
module dct_mac_lane
  import dct_mac_pkg::*;
#(
  parameter int unsigned DWIDTH    = DefDwidth,
  parameter int unsigned CWIDTH    = DefCwidth,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned SAT       = DefSat
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mult_en,
  input  logic signed [DWIDTH-1:0]    din,
  input  logic signed [CWIDTH-1:0]    coef,
  input  logic                        acc_load,
  input  logic                        acc_add,
  input  logic                        done,
  output logic        [ACC_WIDTH-1:0] result,
  output logic                        ovf
);
  localparam int unsigned PW = DWIDTH + CWIDTH;

  logic signed [PW-1:0]        mult_res;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [ACC_WIDTH-1:0] load_val;
  logic                        acc_ovf;
  logic                        add_ovf;
  logic [64:0]                 sa;
  logic                        unused_sa_hi;

  always_comb begin
    sa       = sat_add(64'(acc), 64'(mult_res), ACC_WIDTH, SAT != 0);
    acc_sum  = sa[ACC_WIDTH-1:0];
    add_ovf  = sa[64];
    load_val = ACC_WIDTH'(mult_res);
  end

  assign unused_sa_hi = ^sa[63:ACC_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_res <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      if (mult_en) begin
        mult_res <= PW'(din) * PW'(coef);
      end
      // A first term can never overflow: the product always fits the accumulator.
      if (acc_load) begin
        acc     <= load_val;
        acc_ovf <= 1'b0;
      end else if (acc_add) begin
        acc     <= acc_sum;
        acc_ovf <= acc_ovf | add_ovf;
      end
      if (done) begin
        result <= acc_sum;
        ovf    <= acc_ovf | add_ovf;
      end
    end
  end
endmodule

// File: rtl/dct_mac_lanes.sv
// LANES-wide pipelined multiply-accumulate; shared term counter and valid pipe drive every lane.
module dct_mac_lanes
  import dct_mac_pkg::*;
#(
  parameter int unsigned LANES     = DefLanes,
  parameter int unsigned DWIDTH    = DefDwidth,
  parameter int unsigned CWIDTH    = DefCwidth,
  parameter int unsigned TERMS     = DefTerms,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned SAT       = DefSat
) (
  input logic            clk,
  input logic            rst,
  input logic            ena,
  dct_mac_lanes_if.slave bus
);
  localparam int unsigned CntW = $clog2(TERMS);

  logic                       s1_valid;
  logic                       s1_first;
  logic                       out_valid_q;
  logic [CntW-1:0]            cnt;
  logic                       mult_en;
  logic                       acc_load;
  logic                       acc_add;
  logic                       last;
  logic                       done;
  logic [LANES*ACC_WIDTH-1:0] result_w;
  logic [LANES-1:0]           ovf_w;

  // A non-first term only counts while a sum is open (cnt != 0).
  always_comb begin
    mult_en  = ena & bus.in_valid;
    acc_load = ena & s1_valid & s1_first;
    acc_add  = ena & s1_valid & ~s1_first & (cnt != '0);
    last     = (cnt == CntW'(TERMS - 1));
    done     = acc_add & last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      s1_valid    <= bus.in_valid;
      s1_first    <= bus.dclr;
      out_valid_q <= done;
      if (acc_load) begin
        cnt <= CntW'(1);
      end else if (acc_add) begin
        cnt <= last ? '0 : cnt + CntW'(1);
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dct_mac_lane #(
      .DWIDTH   (DWIDTH),
      .CWIDTH   (CWIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .SAT      (SAT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .mult_en (mult_en),
      .din     (`DCT_LANE(bus.din, i, DWIDTH)),
      .coef    (`DCT_LANE(bus.coef, i, CWIDTH)),
      .acc_load(acc_load),
      .acc_add (acc_add),
      .done    (done),
      .result  (`DCT_LANE(result_w, i, ACC_WIDTH)),
      .ovf     (ovf_w[i])
    );
  end

  assign bus.result    = result_w;
  assign bus.ovf       = ovf_w;
  assign bus.out_valid = out_valid_q & ena;
endmodule

// File: tb/tb_dct_mac_lanes.sv
// Directed bench for dct_mac_lanes: default config plus 22-bit saturating and wrapping variants.
module tb_dct_mac_lanes;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic        dclr;
  logic [31:0] din;
  logic [47:0] coef;

  int          cyc = 0;
  int          pulse_cnt = 0;
  logic [91:0] pulse_res [16];
  int          pulse_cyc [16];
  logic        ov_dis = 1'b0;
  int          term_cyc;
  int          checks = 0;
  int          errors = 0;

  dct_mac_lanes_if #(.LANES(4), .DWIDTH(8), .CWIDTH(12), .ACC_WIDTH(23)) b0 ();
  dct_mac_lanes_if #(.LANES(4), .DWIDTH(8), .CWIDTH(12), .ACC_WIDTH(22)) bs ();
  dct_mac_lanes_if #(.LANES(4), .DWIDTH(8), .CWIDTH(12), .ACC_WIDTH(22)) bw ();

  assign b0.in_valid = in_valid;
  assign b0.dclr     = dclr;
  assign b0.din      = din;
  assign b0.coef     = coef;
  assign bs.in_valid = in_valid;
  assign bs.dclr     = dclr;
  assign bs.din      = din;
  assign bs.coef     = coef;
  assign bw.in_valid = in_valid;
  assign bw.dclr     = dclr;
  assign bw.din      = din;
  assign bw.coef     = coef;

  dct_mac_lanes #(.LANES(4), .DWIDTH(8), .CWIDTH(12), .TERMS(8), .ACC_WIDTH(23), .SAT(0)) dut0 (
    .clk(clk), .rst(rst_n), .ena(ena), .bus(b0.slave)
  );
  dct_mac_lanes #(.LANES(4), .DWIDTH(8), .CWIDTH(12), .TERMS(8), .ACC_WIDTH(22), .SAT(1)) dut_s (
    .clk(clk), .rst(rst_n), .ena(ena), .bus(bs.slave)
  );
  dct_mac_lanes #(.LANES(4), .DWIDTH(8), .CWIDTH(12), .TERMS(8), .ACC_WIDTH(22), .SAT(0)) dut_w (
    .clk(clk), .rst(rst_n), .ena(ena), .bus(bw.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b0.out_valid === 1'b1) begin
      if (pulse_cnt < 16) begin
        pulse_res[pulse_cnt] <= b0.result;
        pulse_cyc[pulse_cnt] <= cyc;
      end
      pulse_cnt <= pulse_cnt + 1;
      if (ena !== 1'b1) ov_dis <= 1'b1;
    end
  end

  function automatic logic [31:0] rep_d(input logic [7:0] v);
    return {4{v}};
  endfunction

  function automatic logic [47:0] rep_c(input logic [11:0] v);
    return {4{v}};
  endfunction

  function automatic logic [91:0] rep_r(input logic [22:0] v);
    return {4{v}};
  endfunction

  task automatic drive(input logic v, input logic clr, input logic [31:0] d, input logic [47:0] c,
                       input logic en);
    in_valid = v;
    dclr     = clr;
    din      = d;
    coef     = c;
    ena      = en;
    term_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic sum8(input logic [47:0] c);
    for (int k = 1; k <= 8; k++) drive(1'b1, k == 1, rep_d(8'(k)), c, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; dclr = 1'b0; din = '0; coef = '0;
    #2;
    checks++;
    if (b0.result !== 92'd0) begin
      errors++; $display("FAIL reset_result got %h want 0", b0.result);
    end
    checks++;
    if (b0.ovf !== 4'd0) begin errors++; $display("FAIL reset_ovf got %h want 0", b0.ovf); end
    checks++;
    if (b0.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", b0.out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    int p0, t8;
    p0 = pulse_cnt;
    sum8(rep_c(12'd2));
    t8 = term_cyc;
    idle(4);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL basic_pulses got %0d want 1", pulse_cnt - p0);
    end
    checks++;
    if (pulse_cyc[p0] !== t8 + 2) begin
      errors++; $display("FAIL basic_latency got %0d want %0d", pulse_cyc[p0], t8 + 2);
    end
    checks++;
    if (pulse_res[p0] !== rep_r(23'd72)) begin
      errors++; $display("FAIL basic_result got %h want %h", pulse_res[p0], rep_r(23'd72));
    end
    checks++;
    if (b0.result !== rep_r(23'd72)) begin
      errors++; $display("FAIL basic_hold got %h want %h", b0.result, rep_r(23'd72));
    end
    checks++;
    if (b0.ovf !== 4'd0) begin errors++; $display("FAIL basic_ovf got %h want 0", b0.ovf); end
  endtask

  task automatic test_lanes;
    logic [91:0] exp_r;
    exp_r = {-23'sd144, 23'sd108, -23'sd72, 23'sd36};
    sum8({-12'sd4, 12'sd3, -12'sd2, 12'sd1});
    idle(4);
    checks++;
    if (b0.result !== exp_r) begin
      errors++; $display("FAIL lanes_result got %h want %h", b0.result, exp_r);
    end
    checks++;
    if (b0.ovf !== 4'd0) begin errors++; $display("FAIL lanes_ovf got %h want 0", b0.ovf); end
  endtask

  task automatic test_extreme;
    for (int k = 0; k < 8; k++) drive(1'b1, k == 0, rep_d(8'h80), rep_c(12'h800), 1'b1);
    idle(4);
    checks++;
    if (b0.result !== rep_r(23'h200000)) begin
      errors++; $display("FAIL ext23_result got %h want %h", b0.result, rep_r(23'h200000));
    end
    checks++;
    if (b0.ovf !== 4'h0) begin errors++; $display("FAIL ext23_ovf got %h want 0", b0.ovf); end
    checks++;
    if (bs.result !== {4{22'h1FFFFF}}) begin
      errors++; $display("FAIL ext_sat_result got %h want %h", bs.result, {4{22'h1FFFFF}});
    end
    checks++;
    if (bs.ovf !== 4'hF) begin errors++; $display("FAIL ext_sat_ovf got %h want f", bs.ovf); end
    checks++;
    if (bw.result !== {4{22'h200000}}) begin
      errors++; $display("FAIL ext_wrap_result got %h want %h", bw.result, {4{22'h200000}});
    end
    checks++;
    if (bw.ovf !== 4'hF) begin errors++; $display("FAIL ext_wrap_ovf got %h want f", bw.ovf); end
  endtask

  task automatic test_reset_mid;
    int p0;
    for (int k = 1; k <= 4; k++) drive(1'b1, k == 1, rep_d(8'(k)), rep_c(12'd2), 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (b0.result !== 92'd0) begin
      errors++; $display("FAIL midrst_result got %h want 0", b0.result);
    end
    checks++;
    if (bs.ovf !== 4'd0) begin errors++; $display("FAIL midrst_ovf got %h want 0", bs.ovf); end
    checks++;
    if (b0.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_out_valid got %b want 0", b0.out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulse_cnt;
    sum8(rep_c(12'd3));
    idle(4);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL midrst_pulses got %0d want 1", pulse_cnt - p0);
    end
    checks++;
    if (b0.result !== rep_r(23'd108)) begin
      errors++; $display("FAIL midrst_fresh got %h want %h", b0.result, rep_r(23'd108));
    end
  endtask

  task automatic test_ignore;
    int p0;
    p0 = pulse_cnt;
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, rep_d(8'd5), rep_c(12'd5), 1'b1);
    idle(4);
    checks++;
    if (pulse_cnt - p0 !== 0) begin
      errors++; $display("FAIL ignore_pulses got %0d want 0", pulse_cnt - p0);
    end
    checks++;
    if (b0.result !== rep_r(23'd108)) begin
      errors++; $display("FAIL ignore_result got %h want %h", b0.result, rep_r(23'd108));
    end
  endtask

  task automatic test_freeze;
    int p0, t0;
    p0 = pulse_cnt;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, k == 1, rep_d(8'(k)), rep_c(12'd2), 1'b1);
      if (k == 1) t0 = term_cyc;
    end
    // Terms offered while disabled must be dropped.
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, rep_d(8'd99), rep_c(12'd7), 1'b0);
    for (int k = 4; k <= 5; k++) drive(1'b1, 1'b0, rep_d(8'(k)), rep_c(12'd2), 1'b1);
    idle(2);
    for (int k = 6; k <= 8; k++) drive(1'b1, 1'b0, rep_d(8'(k)), rep_c(12'd2), 1'b1);
    idle(6);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL freeze_pulses got %0d want 1", pulse_cnt - p0);
    end
    checks++;
    if (pulse_cyc[p0] !== t0 + 14) begin
      errors++; $display("FAIL freeze_latency got %0d want %0d", pulse_cyc[p0], t0 + 14);
    end
    checks++;
    if (pulse_res[p0] !== rep_r(23'd72)) begin
      errors++; $display("FAIL freeze_result got %h want %h", pulse_res[p0], rep_r(23'd72));
    end
    checks++;
    if (ov_dis !== 1'b0) begin
      errors++; $display("FAIL freeze_valid_while_disabled got %b want 0", ov_dis);
    end
  endtask

  task automatic test_abort;
    int p0;
    p0 = pulse_cnt;
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, rep_d(8'd50), rep_c(12'd50), 1'b1);
    sum8(rep_c(12'd2));
    idle(4);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL abort_pulses got %0d want 1", pulse_cnt - p0);
    end
    checks++;
    if (b0.result !== rep_r(23'd72)) begin
      errors++; $display("FAIL abort_result got %h want %h", b0.result, rep_r(23'd72));
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulse_cnt;
    sum8(rep_c(12'd2));
    sum8(rep_c(12'd3));
    sum8(rep_c(12'd4));
    idle(4);
    checks++;
    if (pulse_cnt - p0 !== 3) begin
      errors++; $display("FAIL b2b_pulses got %0d want 3", pulse_cnt - p0);
    end
    checks++;
    if (pulse_cyc[p0+1] - pulse_cyc[p0] !== 8) begin
      errors++; $display("FAIL b2b_gap1 got %0d want 8", pulse_cyc[p0+1] - pulse_cyc[p0]);
    end
    checks++;
    if (pulse_cyc[p0+2] - pulse_cyc[p0+1] !== 8) begin
      errors++; $display("FAIL b2b_gap2 got %0d want 8", pulse_cyc[p0+2] - pulse_cyc[p0+1]);
    end
    checks++;
    if (pulse_res[p0] !== rep_r(23'd72)) begin
      errors++; $display("FAIL b2b_sum1 got %h want %h", pulse_res[p0], rep_r(23'd72));
    end
    checks++;
    if (pulse_res[p0+1] !== rep_r(23'd108)) begin
      errors++; $display("FAIL b2b_sum2 got %h want %h", pulse_res[p0+1], rep_r(23'd108));
    end
    checks++;
    if (pulse_res[p0+2] !== rep_r(23'd144)) begin
      errors++; $display("FAIL b2b_sum3 got %h want %h", pulse_res[p0+2], rep_r(23'd144));
    end
    checks++;
    if (bw.result !== {4{22'd144}} || bw.ovf !== 4'd0) begin
      errors++;
      $display("FAIL b2b_wrap_clear got %h/%h want %h/0", bw.result, bw.ovf, {4{22'd144}});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_extreme();
    test_reset_mid();
    test_ignore();
    test_freeze();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing");
    $fatal(1);
  end
endmodule
